lut3d_cfg_sequencer: RTL and testbench
======================================

Name: lut3d_cfg_sequencer

Overview:
- Upstream feeder for the 3D-LUT colour-mapping stage's configuration port (cfg_data/cfg_valid/cfg_last).
- Accepts a host-side stream of LUT entries with valid/ready, counts them against GS^3 and generates the terminating last flag.
- Gates forwarding to vertical blanking of the pixel timing, so LUT contents change only outside active video.
- Reports progress, completion and framing errors.

Parameters:
- GS, 33: grid size (17, 33 or 65); TOTAL = GS*GS*GS entries per load.
- LUT_CD, 8: bits per LUT colour component; one entry is LUT_CD*3 bits, R in the LSBs.
- VS_POL, 1: vsync active level (1 = active-high).
- CNT_W, $clog2(GS*GS*GS+1): entry counter width (localparam).

Ports:
- p_clk  in  1  pixel clock
- p_rstn  in  1  asynchronous active-low reset
- i_start  in  1  single-cycle arm request
- i_abort  in  1  single-cycle abort request
- i_vs  in  1  pixel vsync, polarity per VS_POL
- i_de  in  1  pixel data enable
- s_data  in  LUT_CD*3  host LUT entry
- s_valid  in  1  host entry valid
- s_last  in  1  host marks final entry
- s_ready  out  1  entry accepted when s_valid&&s_ready
- o_cfg_data  out  LUT_CD*3  entry to LUT RAM
- o_cfg_valid  out  1  entry strobe
- o_cfg_last  out  1  final-entry strobe, qualified by o_cfg_valid
- o_busy  out  1  state != IDLE
- o_done  out  1  one-cycle pulse on a clean, complete load
- o_err  out  1  sticky framing error; cleared by next accepted i_start
- o_cnt  out  CNT_W  entries forwarded in the current load

Behaviour:
- Reset: all outputs 0; state IDLE; counter 0; vblank flag 0.
- Vblank tracking:
  - vs_act = (i_vs == VS_POL), registered once.
  - vblank flag sets on the vs_act rising edge.
  - vblank flag clears on the first cycle with i_de = 1.
  - gate = vblank flag && !i_de.
- States:
  - IDLE: i_start -> ARMED, o_err <= 0, o_cnt <= 0.
  - ARMED: waits for the next vs_act rising edge -> LOAD. Loading never starts mid-frame, even if vblank is already active.
  - LOAD: s_ready = gate. Each accepted beat is registered to o_cfg_*, with exactly 1-cycle latency, and increments o_cnt. A load may span several frames; it pauses whenever gate = 0.
  - DRAIN: s_ready = 1. Entries are discarded and o_cfg_valid stays 0. Accepting s_last -> IDLE.
- Accepted beat in LOAD, with n = o_cnt before the increment:
  - n == TOTAL-1 and s_last: o_cfg_last = 1, o_done pulses 1 cycle after the beat, -> IDLE.
  - n == TOTAL-1 and !s_last: o_cfg_last = 1, o_err = 1, -> DRAIN.
  - n < TOTAL-1 and s_last: forwarded with o_cfg_last = 0, o_err = 1, -> IDLE. No last is issued and the LUT is left partial.
- o_cfg_valid and o_cfg_last are single-cycle pulses. o_cfg_data holds its last value when valid = 0.
- i_abort in any non-IDLE state -> IDLE next cycle. No further o_cfg_valid, no o_done, o_err unchanged. Abort has priority over a same-cycle beat, so that beat is not accepted (s_ready is forced to 0).
- i_start outside IDLE is ignored. i_start together with i_abort: abort wins.
- Asynchronous reset mid-load: immediate return to IDLE and all outputs 0. Downstream LUT content is then undefined until a new load completes.
- o_done and o_err never assert in the same cycle.

Decomposition:
- Shared package lut3d_pkg holds:
  - enum cfg_seq_state_t {IDLE, ARMED, LOAD, DRAIN};
  - function lut_total(gs) returning gs*gs*gs;
  - typedef of the LUT_CD*3 entry type, shared with the LUT RAM.
- One sub-module: vblank_detect. Inputs are vs, de and VS_POL; outputs are vs_rise and in_vblank. It is reusable by other frame-synchronous config blocks.

Test Plan (GS=3, TOTAL=27, LUT_CD=8, VS_POL=1):
- Clean load: i_start, vs pulse, 27 beats with data = index, s_last on beat 27, i_de held 0 → 27 o_cfg_valid beats with data 0..26, one cycle after each acceptance; o_cfg_last on beat 27; o_done pulses; o_cnt = 27; o_err = 0.
- Blanking gate: vblank active, i_de rises after 10 accepted beats, next vs pulse follows → s_ready = 0 while i_de = 1 and until vs; remaining 17 beats forwarded in the next vblank; data order intact.
- Early last: s_last on beat 20 → 20 beats forwarded, none with o_cfg_last; o_err = 1; state IDLE; no o_done.
- Missing last: 30 beats, s_last on beat 30 → beat 27 carries o_cfg_last; o_err = 1; beats 28-30 accepted and dropped (no o_cfg_valid); return to IDLE after beat 30.
- Abort: i_abort asserted in the same cycle as beat 5 → beat 5 not accepted; o_cnt = 4; state IDLE; no o_cfg_last; a subsequent i_start clears o_cnt and reloads all 27 entries correctly.
- Arm mid-vblank: i_start while vblank is already active → no s_ready until the next vs rising edge; then the load proceeds as in the clean-load case.

Source files
------------

// File: rtl/lut3d_pkg.sv
// Shared types and helpers for the 3D-LUT configuration path.
// The entry type is also used by the LUT RAM so both sides agree on packing (R in the LSBs).
package lut3d_pkg;

  localparam int LUT_CD_DFLT = 8;

  typedef logic [LUT_CD_DFLT*3-1:0] lut_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    LOAD,
    DRAIN
  } cfg_seq_state_t;

  function automatic int lut_total(input int gs);
    return gs * gs * gs;
  endfunction

endpackage

// File: rtl/lut3d_cfg_sequencer_vblank_detect.sv
// Vertical-blanking tracker for frame-synchronous configuration blocks.
// The flag is set by a vsync activation edge and cleared by the first active pixel.
module vblank_detect
  import lut3d_pkg::*;
#(
  parameter bit VS_POL = 1'b1
) (
  input  logic p_clk,
  input  logic p_rstn,
  input  logic vs,
  input  logic de,
  output logic vs_rise,
  output logic in_vblank
);

  logic vs_act;
  logic vs_act_d;

  assign vs_rise = vs_act & ~vs_act_d;

  always_ff @(posedge p_clk or negedge p_rstn) begin
    if (!p_rstn) begin
      vs_act    <= 1'b0;
      vs_act_d  <= 1'b0;
      in_vblank <= 1'b0;
    end else begin
      vs_act   <= (vs == VS_POL);
      vs_act_d <= vs_act;
      // Active video always wins over a coincident vsync edge.
      if (de) begin
        in_vblank <= 1'b0;
      end else if (vs_rise) begin
        in_vblank <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/lut3d_cfg_sequencer.sv
// Feeds host LUT entries to the 3D-LUT config port, only during vertical blanking,
// counting against GS^3 to generate cfg_last and flag framing errors.
module lut3d_cfg_sequencer
  import lut3d_pkg::*;
#(
  parameter int  GS     = 33,
  parameter int  LUT_CD = 8,
  parameter bit  VS_POL = 1'b1,
  localparam int CNT_W  = $clog2(GS*GS*GS+1)
) (
  input  logic                  p_clk,
  input  logic                  p_rstn,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic                  i_vs,
  input  logic                  i_de,
  input  logic [LUT_CD*3-1:0]   s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [LUT_CD*3-1:0]   o_cfg_data,
  output logic                  o_cfg_valid,
  output logic                  o_cfg_last,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [CNT_W-1:0]      o_cnt
);

  localparam int             TOTAL    = lut_total(GS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL - 1);

  cfg_seq_state_t state;
  logic           vs_rise;
  logic           in_vblank;
  logic           gate;
  logic           accept;

  vblank_detect #(
    .VS_POL (VS_POL)
  ) u_vblank (
    .p_clk     (p_clk),
    .p_rstn    (p_rstn),
    .vs        (i_vs),
    .de        (i_de),
    .vs_rise   (vs_rise),
    .in_vblank (in_vblank)
  );

  assign gate    = in_vblank & ~i_de;
  // Abort masks ready so a coincident beat is never consumed.
  assign s_ready = ~i_abort & (((state == LOAD) & gate) | (state == DRAIN));
  assign accept  = s_valid & s_ready;
  assign o_busy  = (state != IDLE);

  always_ff @(posedge p_clk or negedge p_rstn) begin
    if (!p_rstn) begin
      state       <= IDLE;
      o_cfg_data  <= '0;
      o_cfg_valid <= 1'b0;
      o_cfg_last  <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_cnt       <= '0;
    end else begin
      o_cfg_valid <= 1'b0;
      o_cfg_last  <= 1'b0;
      o_done      <= 1'b0;

      if (state != IDLE && i_abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (i_start && !i_abort) begin
              state <= ARMED;
              o_err <= 1'b0;
              o_cnt <= '0;
            end
          end

          // Wait for a fresh vsync edge even if already in blanking.
          ARMED: begin
            if (vs_rise) begin
              state <= LOAD;
            end
          end

          LOAD: begin
            if (accept) begin
              o_cfg_data  <= s_data;
              o_cfg_valid <= 1'b1;
              o_cnt       <= o_cnt + CNT_W'(1);
              if (o_cnt == LAST_IDX) begin
                o_cfg_last <= 1'b1;
                if (s_last) begin
                  o_done <= 1'b1;
                  state  <= IDLE;
                end else begin
                  o_err <= 1'b1;
                  state <= DRAIN;
                end
              end else if (s_last) begin
                o_err <= 1'b1;
                state <= IDLE;
              end
            end
          end

          DRAIN: begin
            if (accept && s_last) begin
              state <= IDLE;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lut3d_cfg_sequencer.sv
// Directed-plus-random bench for lut3d_cfg_sequencer (GS=3, 8-bit components, active-high vsync).
// Expected config beats come from a load-level model of entry counting and framing rules.
module tb_lut3d_cfg_sequencer;
  import lut3d_pkg::*;

  localparam int GS    = 3;
  localparam int LCD   = 8;
  localparam int TOTAL = 27;
  localparam int CW    = 5;

  logic             p_clk = 1'b0;
  logic             p_rstn;
  logic             i_start, i_abort, i_vs, i_de;
  lut_entry_t       s_data;
  logic             s_valid, s_last, s_ready;
  lut_entry_t       o_cfg_data;
  logic             o_cfg_valid, o_cfg_last, o_busy, o_done, o_err;
  logic [CW-1:0]    o_cnt;

  int total = 0;
  int bad   = 0;
  int m_cnt;
  bit m_err, m_drain;
  bit last_acc, last_ready;
  int done_seen;

  always #5 p_clk = ~p_clk;

  lut3d_cfg_sequencer #(
    .GS     (GS),
    .LUT_CD (LCD),
    .VS_POL (1'b1)
  ) dut (
    .p_clk       (p_clk),
    .p_rstn      (p_rstn),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .i_vs        (i_vs),
    .i_de        (i_de),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .o_cfg_data  (o_cfg_data),
    .o_cfg_valid (o_cfg_valid),
    .o_cfg_last  (o_cfg_last),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_cnt       (o_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: handshake sampled mid-cycle, model updated, outputs checked just after the edge.
  task automatic tick();
    bit         acc, l, e_valid, e_last, e_done;
    lut_entry_t d;
    @(negedge p_clk);
    acc        = s_valid && s_ready;
    last_ready = s_ready;
    d          = s_data;
    l          = s_last;
    e_valid = 0; e_last = 0; e_done = 0;
    if (acc) begin
      if (!m_drain) begin
        e_valid = 1;
        e_last  = (m_cnt == TOTAL - 1);
        m_cnt++;
        if (m_cnt == TOTAL && l) e_done = 1;
        else if (m_cnt == TOTAL) begin m_err = 1; m_drain = 1; end
        else if (l) m_err = 1;
      end else if (l) begin
        m_drain = 0;
      end
    end
    @(posedge p_clk);
    #1;
    chk("cfg_valid", o_cfg_valid, e_valid);
    if (e_valid) begin
      chk("cfg_data", o_cfg_data, d);
      chk("cfg_last", o_cfg_last, e_last);
    end
    chk("done", o_done, e_done);
    chk("err", o_err, m_err);
    chk("cnt", o_cnt, m_cnt);
    if (o_done) done_seen++;
    last_acc = acc;
  endtask

  task automatic start_load();
    i_start = 1; m_err = 0; m_cnt = 0; m_drain = 0;
    tick();
    i_start = 0;
    chk("start_busy", o_busy, 1);
  endtask

  task automatic vs_pulse();
    i_vs = 1; tick(); tick();
    i_vs = 0; tick();
  endtask

  task automatic send_beat(input lut_entry_t d, input bit l);
    int n;
    s_valid = 1; s_data = d; s_last = l;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 100);
    if (!last_acc) chk("beat_timeout", 32'(n), 0);
    s_valid = 0; s_last = 0;
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic run_load(input int nbeats, input int last_at, input bit rnd);
    for (int i = 1; i <= nbeats; i++)
      send_beat(rnd ? lut_entry_t'($urandom) : lut_entry_t'(i - 1), i == last_at);
  endtask

  initial begin
    p_rstn = 0; i_start = 0; i_abort = 0; i_vs = 0; i_de = 0;
    s_data = '0; s_valid = 0; s_last = 0;
    m_cnt = 0; m_err = 0; m_drain = 0; done_seen = 0;
    #1;
    chk("rst_valid", o_cfg_valid, 0);
    chk("rst_last",  o_cfg_last, 0);
    chk("rst_data",  o_cfg_data, 0);
    chk("rst_busy",  o_busy, 0);
    chk("rst_done",  o_done, 0);
    chk("rst_err",   o_err, 0);
    chk("rst_cnt",   o_cnt, 0);
    chk("rst_ready", s_ready, 0);
    repeat (2) @(negedge p_clk);
    p_rstn = 1;
    tick();

    // clean load, data = index
    start_load();
    vs_pulse();
    run_load(TOTAL, TOTAL, 0);
    chk("clean_busy", o_busy, 0);
    chk("clean_cnt", o_cnt, TOTAL);
    chk("clean_done_seen", done_seen, 1);

    // blanking gate: active video after 10 beats pauses the load until the next vsync
    start_load();
    vs_pulse();
    run_load(10, 0, 1);
    i_de = 1; s_valid = 1; s_data = lut_entry_t'($urandom);
    repeat (5) begin tick(); chk("gate_de_ready", last_ready, 0); end
    i_de = 0;
    repeat (3) begin tick(); chk("gate_wait_ready", last_ready, 0); end
    s_valid = 0;
    vs_pulse();
    for (int i = 11; i <= TOTAL; i++) send_beat(lut_entry_t'($urandom), i == TOTAL);
    chk("gate_busy", o_busy, 0);
    chk("gate_done_seen", done_seen, 2);

    // early last on beat 20
    start_load();
    vs_pulse();
    run_load(20, 20, 1);
    chk("early_busy", o_busy, 0);
    chk("early_err", o_err, 1);
    chk("early_cnt", o_cnt, 20);
    chk("early_done_seen", done_seen, 2);

    // missing last: 30 beats, last on 30
    start_load();
    vs_pulse();
    run_load(29, 0, 1);
    chk("miss_busy_drain", o_busy, 1);
    send_beat(lut_entry_t'($urandom), 1);
    chk("miss_busy", o_busy, 0);
    chk("miss_err", o_err, 1);
    chk("miss_cnt", o_cnt, TOTAL);

    // abort coincident with beat 5, then a full reload
    start_load();
    vs_pulse();
    run_load(4, 0, 1);
    s_valid = 1; s_data = lut_entry_t'($urandom); i_abort = 1;
    tick();
    chk("abort_ready", last_ready, 0);
    i_abort = 0; s_valid = 0;
    chk("abort_busy", o_busy, 0);
    chk("abort_cnt", o_cnt, 4);
    repeat (3) tick();
    start_load();
    chk("reload_cnt_clr", o_cnt, 0);
    vs_pulse();
    run_load(TOTAL, TOTAL, 1);
    chk("reload_busy", o_busy, 0);
    chk("reload_done_seen", done_seen, 3);

    // arm while blanking is already active: must wait for the next vsync edge
    start_load();
    s_valid = 1; s_data = lut_entry_t'($urandom);
    repeat (8) begin tick(); chk("midvb_ready", last_ready, 0); end
    s_valid = 0;
    vs_pulse();
    run_load(TOTAL, TOTAL, 0);
    chk("midvb_done_seen", done_seen, 4);

    // asynchronous reset in the middle of a load
    start_load();
    vs_pulse();
    run_load(5, 0, 1);
    s_valid = 1;
    @(posedge p_clk);
    #3 p_rstn = 0;
    #1;
    m_cnt = 0; m_err = 0; m_drain = 0;
    chk("arst_busy",  o_busy, 0);
    chk("arst_cnt",   o_cnt, 0);
    chk("arst_valid", o_cfg_valid, 0);
    chk("arst_data",  o_cfg_data, 0);
    chk("arst_ready", s_ready, 0);
    s_valid = 0;
    @(negedge p_clk);
    p_rstn = 1;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
